// File: rtl/ats21_client_port.sv
// ATS21 control-port initiator: queues host instructions, sends each as two 16-bit
// beats with Nack retry, reports completion, and captures alarm edges as W1C bits.
module ats21_client_port #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned STAT_LAT   = 1,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned NUM_ALARMS = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [31:0]           cmd_data,
    output logic                  rsp_valid,
    output logic                  rsp_ack,
    output logic [1:0]            rsp_retries,
    output logic                  busy,
    output logic                  ats_req,
    output logic [15:0]           ats_ctrl,
    input  logic                  ats_stat,
    input  logic [NUM_ALARMS-1:0] ats_data,
    input  logic [NUM_ALARMS-1:0] alarm_clr,
    output logic [NUM_ALARMS-1:0] alarm_pending,
    output logic                  alarm_irq
);

    localparam int unsigned AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned WCNT_W = (STAT_LAT > 1) ? $clog2(STAT_LAT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(STAT_LAT - 1);
    localparam logic [1:0]        RETRY_MAX = 2'(MAX_RETRY);
    localparam logic [AW:0]       CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_WAIT,
        S_GAP,
        S_RESP
    } state_t;

    state_t            state;
    logic [31:0]       instr;
    logic [1:0]        retry_cnt;
    logic [WCNT_W-1:0] wcnt;

    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       fifo_cnt;
    logic [31:0]       fifo_head;
    logic              push;
    logic              pop;

    logic [NUM_ALARMS-1:0] ats_data_q;

    assign cmd_ready = (fifo_cnt != CNT_FULL);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == S_IDLE) && (fifo_cnt != '0);
    assign fifo_head = fifo_mem[rd_ptr];
    assign busy      = (state != S_IDLE) || (fifo_cnt != '0);

    // Command FIFO storage; contents need no reset since the count guards reads.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cmd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Transfer FSM; bus outputs are loaded on entry so they are valid for the whole state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            instr       <= '0;
            retry_cnt   <= '0;
            wcnt        <= '0;
            ats_req     <= 1'b0;
            ats_ctrl    <= '0;
            rsp_valid   <= 1'b0;
            rsp_ack     <= 1'b0;
            rsp_retries <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        instr     <= fifo_head;
                        retry_cnt <= '0;
                        if (fifo_head[31:29] == 3'b000) begin
                            state       <= S_RESP;
                            rsp_valid   <= 1'b1;
                            rsp_ack     <= 1'b1;
                            rsp_retries <= '0;
                        end else begin
                            state    <= S_HI;
                            ats_req  <= 1'b1;
                            ats_ctrl <= fifo_head[31:16];
                        end
                    end
                end
                S_HI: begin
                    state    <= S_LO;
                    ats_ctrl <= instr[15:0];
                end
                S_LO: begin
                    state    <= S_WAIT;
                    ats_req  <= 1'b0;
                    ats_ctrl <= '0;
                    wcnt     <= '0;
                end
                S_WAIT: begin
                    if (wcnt == WCNT_LAST) begin
                        if (ats_stat) begin
                            state       <= S_RESP;
                            rsp_valid   <= 1'b1;
                            rsp_ack     <= 1'b1;
                            rsp_retries <= retry_cnt;
                        end else if (retry_cnt < RETRY_MAX) begin
                            state     <= S_GAP;
                            retry_cnt <= retry_cnt + 1'b1;
                        end else begin
                            state       <= S_RESP;
                            rsp_valid   <= 1'b1;
                            rsp_ack     <= 1'b0;
                            rsp_retries <= retry_cnt;
                        end
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_GAP: begin
                    state    <= S_HI;
                    ats_req  <= 1'b1;
                    ats_ctrl <= instr[31:16];
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Alarm edge capture; a new rise wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ats_data_q    <= '0;
            alarm_pending <= '0;
            alarm_irq     <= 1'b0;
        end else begin
            ats_data_q    <= ats_data;
            alarm_pending <= (alarm_pending & ~alarm_clr) | (ats_data & ~ats_data_q);
            alarm_irq     <= |alarm_pending;
        end
    end

endmodule

// File: tb/tb_ats21_client_port.sv
// Scoreboard bench for ats21_client_port: a negedge device model answers beats,
// expected responses are queued at each accepted push and checked at rsp_valid.
module tb_ats21_client_port;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned STAT_LAT   = 1;
    localparam int unsigned MAX_RETRY  = 3;
    localparam int unsigned NUM_ALARMS = 24;

    typedef struct {
        logic [31:0] data;
        logic        ack;
        logic [1:0]  retries;
        int          push_cyc;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [31:0]           cmd_data;
    logic                  rsp_valid;
    logic                  rsp_ack;
    logic [1:0]            rsp_retries;
    logic                  busy;
    logic                  ats_req;
    logic [15:0]           ats_ctrl;
    logic                  ats_stat = 1'b0;
    logic [NUM_ALARMS-1:0] ats_data;
    logic [NUM_ALARMS-1:0] alarm_clr;
    logic [NUM_ALARMS-1:0] alarm_pending;
    logic                  alarm_irq;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          ncyc = 0;
    int          nacks_per_cmd = 0;
    int          attempts = 0;
    int          req_run = 0;
    logic [15:0] hi_beat = '0;
    bit          check_latency = 1'b0;

    ats21_client_port #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .STAT_LAT   (STAT_LAT),
        .MAX_RETRY  (MAX_RETRY),
        .NUM_ALARMS (NUM_ALARMS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_data      (cmd_data),
        .rsp_valid     (rsp_valid),
        .rsp_ack       (rsp_ack),
        .rsp_retries   (rsp_retries),
        .busy          (busy),
        .ats_req       (ats_req),
        .ats_ctrl      (ats_ctrl),
        .ats_stat      (ats_stat),
        .ats_data      (ats_data),
        .alarm_clr     (alarm_clr),
        .alarm_pending (alarm_pending),
        .alarm_irq     (alarm_irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard push, device responder and response checker, all on the quiet edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        ncyc++;
        if (reset) begin
            exp_q.delete();
            req_run  = 0;
            attempts = 0;
            ats_stat = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                e.data     = cmd_data;
                e.push_cyc = ncyc;
                if (cmd_data[31:29] == 3'b000) begin
                    e.ack     = 1'b1;
                    e.retries = 2'd0;
                end else if (nacks_per_cmd > int'(MAX_RETRY)) begin
                    e.ack     = 1'b0;
                    e.retries = 2'(MAX_RETRY);
                end else begin
                    e.ack     = 1'b1;
                    e.retries = 2'(nacks_per_cmd);
                end
                exp_q.push_back(e);
            end
            if (ats_req) begin
                req_run++;
                if (req_run == 1) begin
                    hi_beat  = ats_ctrl;
                    ats_stat = 1'b0;
                end else if (req_run == 2) begin
                    attempts++;
                    check_eq("beat_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        check_eq("beat_word", {hi_beat, ats_ctrl}, exp_q[0].data);
                    end
                    ats_stat = (attempts > nacks_per_cmd);
                end
            end else begin
                if (req_run != 0) begin
                    check_eq("req_run_len", 32'(req_run), 32'd2);
                end
                req_run = 0;
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("rsp_ack", 32'(rsp_ack), 32'(e.ack));
                    check_eq("rsp_retries", 32'(rsp_retries), 32'(e.retries));
                    check_eq("attempts", 32'(attempts),
                             (e.data[31:29] == 3'b000) ? 32'd0 : 32'(e.retries) + 32'd1);
                    if (check_latency) begin
                        check_eq("rsp_latency", 32'(ncyc - e.push_cyc), 32'(4 + STAT_LAT));
                    end
                end
                attempts = 0;
            end
        end
    end

    task automatic push(input logic [31:0] w);
        bit ok;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_data  = w;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            check_eq("push_timeout", 32'(cmd_ready), 32'd1);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        bit done;
        done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            @(posedge clk);
            #1;
            done = (exp_q.size() == 0) && !busy;
        end
        if (!done) begin
            check_eq("idle_timeout_pending", 32'(exp_q.size()), 32'd0);
        end
    endtask

    task automatic tick_check_alarm(input string tag, input logic [23:0] exp_pend,
                                    input logic exp_irq);
        @(posedge clk);
        #1;
        check_eq({tag, "_pending"}, 32'(alarm_pending), 32'(exp_pend));
        check_eq({tag, "_irq"}, 32'(alarm_irq), 32'(exp_irq));
    endtask

    initial begin
        bit seen_lo;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        ats_data  = '0;
        alarm_clr = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req", 32'(ats_req), 32'd0);
        check_eq("rst_ctrl", 32'(ats_ctrl), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_pending", 32'(alarm_pending), 32'd0);
        check_eq("rst_irq", 32'(alarm_irq), 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single acked instruction with latency check
        nacks_per_cmd = 0;
        check_latency = 1'b1;
        push(32'h2A40_1234);
        wait_idle(100);
        check_latency = 1'b0;

        // Permanent Nack, then two Nacks before Ack
        nacks_per_cmd = 9;
        push(32'h6000_00F0);
        wait_idle(200);
        nacks_per_cmd = 2;
        push(32'hE123_4567);
        wait_idle(200);

        // Five back-to-back pushes with a stalled device fill the FIFO
        nacks_per_cmd = 9;
        push(32'h2000_0001);
        push(32'h4000_0002);
        push(32'h6000_0003);
        push(32'h8000_0004);
        push(32'hA000_0005);
        check_eq("fifo_full_ready", 32'(cmd_ready), 32'd0);
        check_eq("fifo_full_busy", 32'(busy), 32'd1);
        wait_idle(1000);

        // Opcode 000 completes without bus traffic; mixed with a normal command
        nacks_per_cmd = 0;
        push(32'h0000_0000);
        push(32'h3FFF_ABCD);
        wait_idle(200);

        // Alarm capture
        ats_data  = 24'h020008;
        alarm_clr = 24'h020000;
        tick_check_alarm("alm_set", 24'h020008, 1'b0);
        ats_data  = 24'h000008;
        alarm_clr = '0;
        tick_check_alarm("alm_hold", 24'h020008, 1'b1);
        alarm_clr = 24'h000008;
        tick_check_alarm("alm_clr3", 24'h020000, 1'b1);
        alarm_clr = '0;
        tick_check_alarm("alm_level", 24'h020000, 1'b1);
        ats_data = '0;
        tick_check_alarm("alm_low", 24'h020000, 1'b1);
        ats_data = 24'h000008;
        tick_check_alarm("alm_rearm", 24'h020008, 1'b1);
        ats_data  = '0;
        alarm_clr = '1;
        tick_check_alarm("alm_clrall", 24'h000000, 1'b1);
        alarm_clr = '0;
        tick_check_alarm("alm_irq_drop", 24'h000000, 1'b0);

        // Reset during the low beat aborts the transfer
        nacks_per_cmd = 9;
        push(32'h4321_5678);
        seen_lo = 1'b0;
        for (int i = 0; i < 50 && !seen_lo; i++) begin
            @(negedge clk);
            seen_lo = ats_req && (ats_ctrl == 16'h5678);
        end
        check_eq("lo_seen", 32'(seen_lo), 32'd1);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_req", 32'(ats_req), 32'd0);
        check_eq("abort_ctrl", 32'(ats_ctrl), 32'd0);
        check_eq("abort_ready", 32'(cmd_ready), 32'd1);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_eq("post_abort_busy", 32'(busy), 32'd0);

        nacks_per_cmd = 1;
        push(32'hC0DE_0001);
        wait_idle(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
